// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : vram_arbiter
// Four-slot single-port VRAM arbiter: video reads own slots 1/2, a host
// request FIFO drains in slots 0/3. Option macro VRAM_ARB_VBLANK_BOOST_EN
// hands slots 1/2 to the host while vblank is high.
// Rev    : 1.0
// ============================================================================

module vram_arbiter #(
   parameter int AW         = 13,
   parameter int DW         = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   output logic [1:0]    phase,
   input  logic [AW-1:0] vid_addr,
   output logic [DW-1:0] vid_rdata,
   output logic          vid_valid,
   input  logic          host_valid,
   output logic          host_ready,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic [DW-1:0] host_rdata,
   output logic          host_rvalid,
   input  logic          vblank,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int                c_PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [c_PTR_W:0]  c_DEPTH = (c_PTR_W + 1)'(FIFO_DEPTH);

   logic [1:0]            r_phase;
   logic [AW-1:0]         r_fifo_addr  [FIFO_DEPTH];
   logic [DW-1:0]         r_fifo_wdata [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_fifo_we;
   logic [c_PTR_W-1:0]    r_wr_ptr;
   logic [c_PTR_W-1:0]    r_rd_ptr;
   logic [c_PTR_W:0]      r_count;
   logic                  r_s1_vid;
   logic                  r_s1_host;
   logic                  r_vid_valid;
   logic                  r_host_rvalid;
   logic [DW-1:0]         r_vid_rdata;
   logic [DW-1:0]         r_host_rdata;

   logic w_video_slot;
   logic w_host_slot;
   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_pop;
   logic w_vid_issue;
   logic w_host_rd;

   assign w_video_slot = r_phase[0] ^ r_phase[1];

`ifdef VRAM_ARB_VBLANK_BOOST_EN
   assign w_host_slot = ~w_video_slot | vblank;
`else
   logic w_unused_vblank;
   assign w_unused_vblank = vblank;
   assign w_host_slot     = ~w_video_slot;
`endif

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == c_DEPTH);
   assign host_ready  = ~rst & ~w_full;
   assign w_push      = host_valid & host_ready;
   assign w_pop       = ~rst & w_host_slot & ~w_empty;
   // A host-owned slot never issues a video read, even with an empty FIFO.
   assign w_vid_issue = ~rst & ~w_host_slot;
   assign w_host_rd   = w_pop & ~r_fifo_we[r_rd_ptr];

   assign mem_addr  = w_pop ? r_fifo_addr[r_rd_ptr]  : vid_addr;
   assign mem_we    = w_pop & r_fifo_we[r_rd_ptr];
   assign mem_wdata = w_pop ? r_fifo_wdata[r_rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr]  <= host_addr;
         r_fifo_wdata[r_wr_ptr] <= host_wdata;
         r_fifo_we[r_wr_ptr]    <= host_we;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase  <= 2'd0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_phase <= r_phase + 2'd1;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (!w_push && w_pop)
            r_count <= r_count - 1'b1;
      end
   end

   // Stage 1 waits out the memory latency; stage 2 registers the returned word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vid      <= 1'b0;
         r_s1_host     <= 1'b0;
         r_vid_valid   <= 1'b0;
         r_host_rvalid <= 1'b0;
         r_vid_rdata   <= '0;
         r_host_rdata  <= '0;
      end else begin
         r_s1_vid      <= w_vid_issue;
         r_s1_host     <= w_host_rd;
         r_vid_valid   <= r_s1_vid;
         r_host_rvalid <= r_s1_host;
         if (r_s1_vid)  r_vid_rdata  <= mem_rdata;
         if (r_s1_host) r_host_rdata <= mem_rdata;
      end
   end

   assign phase       = rst ? 2'd0 : r_phase;
   assign vid_valid   = ~rst & r_vid_valid;
   assign host_rvalid = ~rst & r_host_rvalid;
   assign vid_rdata   = rst ? '0 : r_vid_rdata;
   assign host_rdata  = rst ? '0 : r_host_rdata;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_vram_arbiter
// Self-checking bench for vram_arbiter against a queue-based slot model.
// Rev    : 1.0
// ============================================================================

module tb_vram_arbiter;

   localparam int AW    = 13;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    phase;
   logic [AW-1:0] vid_addr = '0;
   logic [DW-1:0] vid_rdata;
   logic          vid_valid;
   logic          host_valid = 1'b0;
   logic          host_ready;
   logic          host_we = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;
   logic [DW-1:0] host_rdata;
   logic          host_rvalid;
   logic          vblank = 1'b0;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   vram_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .phase(phase),
      .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_valid(vid_valid),
      .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(host_rdata), .host_rvalid(host_rvalid),
      .vblank(vblank),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Single-port synchronous memory with one cycle of read latency.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   // Reference model: host requests as a queue, responses as a due-cycle queue.
   typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
   typedef struct { int due; bit host; logic [DW-1:0] data; } rsp_t;

   req_t          m_q[$];
   rsp_t          m_rsp[$];
   logic [DW-1:0] m_mem [0:(1<<AW)-1];
   logic [DW-1:0] m_vid;
   logic [DW-1:0] m_host;
   int            m_phase;
   int            cyc;

   logic [1:0]    exp_phase;
   logic          exp_ready, exp_mem_we, exp_vid_valid, exp_host_rvalid;
   logic [AW-1:0] exp_mem_addr;
   logic [DW-1:0] exp_mem_wdata, exp_vid_rdata, exp_host_rdata;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic model_cycle();
      req_t r;
      rsp_t s;
      bit   hslot, ready0;
      exp_vid_valid   = 1'b0;
      exp_host_rvalid = 1'b0;
      exp_mem_we      = 1'b0;
      exp_mem_addr    = vid_addr;
      exp_mem_wdata   = '0;
      if (rst) begin
         m_q.delete();
         m_rsp.delete();
         m_phase   = 0;
         m_vid     = '0;
         m_host    = '0;
         exp_phase = 2'd0;
         exp_ready = 1'b0;
      end else begin
         exp_phase = 2'(m_phase);
         if (m_rsp.size() > 0 && m_rsp[0].due == cyc) begin
            s = m_rsp.pop_front();
            if (s.host) begin m_host = s.data; exp_host_rvalid = 1'b1; end
            else        begin m_vid  = s.data; exp_vid_valid   = 1'b1; end
         end
         ready0    = (m_q.size() < DEPTH);
         exp_ready = ready0;
         hslot     = (m_phase == 0 || m_phase == 3);
`ifdef VRAM_ARB_VBLANK_BOOST_EN
         if (vblank) hslot = 1'b1;
`endif
         if (hslot && m_q.size() > 0) begin
            r             = m_q.pop_front();
            exp_mem_addr  = r.addr;
            exp_mem_we    = r.we;
            exp_mem_wdata = r.data;
            if (r.we) m_mem[r.addr] = r.data;
            else      m_rsp.push_back('{due: cyc + 2, host: 1'b1, data: m_mem[r.addr]});
         end else if (!hslot) begin
            m_rsp.push_back('{due: cyc + 2, host: 1'b0, data: m_mem[vid_addr]});
         end
         if (host_valid && ready0)
            m_q.push_back('{we: host_we, addr: host_addr, data: host_wdata});
         m_phase = (m_phase + 1) % 4;
      end
      exp_vid_rdata  = m_vid;
      exp_host_rdata = m_host;
      cyc++;
   endtask

   // Inputs change 1 time unit after the edge; outputs sampled 4 units after.
   task automatic drive(input logic r, input logic hv, input logic hw,
                        input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                        input logic [AW-1:0] va, input logic vb);
      @(posedge clk);
      #1;
      rst = r; host_valid = hv; host_we = hw; host_addr = ha;
      host_wdata = hd; vid_addr = va; vblank = vb;
      #3;
      model_cycle();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 1'b0, '0, '0, 13'h0123, 1'b0);
         n_checks++;
         if ({phase, host_ready, vid_valid, host_rvalid, mem_we, vid_rdata, host_rdata} !== '0)
            $display("FAIL reset_state: got ph=%0d rdy=%b vv=%b hv=%b we=%b vd=%h hd=%h required all zero",
                     phase, host_ready, vid_valid, host_rvalid, mem_we, vid_rdata, host_rdata);
         else n_pass++;
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b0, '0, '0, 13'h0123, 1'b0);
         n_checks++;
         if (phase !== 2'(i % 4))
            $display("FAIL reset_phase_seq: got %0d required %0d", phase, i % 4);
         else n_pass++;
         if (i == 0) begin
            n_checks++;
            if (host_ready !== 1'b1)
               $display("FAIL reset_ready_release: got %b required 1", host_ready);
            else n_pass++;
         end
      end
   endtask

   task automatic test_video();
      int nv = 0;
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 1'b0, 1'b0, '0, '0, 13'h0123, 1'b0);
         n_checks++;
         if (mem_addr !== 13'h0123 || mem_we !== 1'b0)
            $display("FAIL video_addr: got addr=%h we=%b required 0123/0", mem_addr, mem_we);
         else n_pass++;
         n_checks++;
         if (vid_valid !== (phase == 2'd3 || phase == 2'd0))
            $display("FAIL video_valid_slot: got %b in phase %0d", vid_valid, phase);
         else n_pass++;
         if (vid_valid) begin
            nv++;
            n_checks++;
            if (vid_rdata !== 16'hF81F)
               $display("FAIL video_rdata: got %h required F81F", vid_rdata);
            else n_pass++;
         end
      end
      n_checks++;
      if (nv != 6) $display("FAIL video_pulse_count: got %0d required 6", nv);
      else n_pass++;
   endtask

   task automatic test_fifo_fill();
      int k = 0, n_wr = 0, guard = 0;
      while (m_phase != 0) drive(1'b0, 1'b0, 1'b0, '0, '0, 13'h0123, 1'b0);
      while ((k < 8 || m_q.size() > 0) && guard < 60) begin
         guard++;
         drive(1'b0, k < 8, 1'b1, AW'(16 + k), DW'(16'hA000 + k), 13'h0123, 1'b0);
         if (k < 8 && exp_ready) k++;
         n_checks++;
         if (host_ready !== exp_ready || mem_we !== exp_mem_we)
            $display("FAIL fill_ready_we: got rdy=%b we=%b required rdy=%b we=%b",
                     host_ready, mem_we, exp_ready, exp_mem_we);
         else n_pass++;
         if (mem_we) begin
            n_checks++;
            if ((phase != 2'd0 && phase != 2'd3) || mem_addr !== AW'(16 + n_wr)
                || mem_wdata !== DW'(16'hA000 + n_wr))
               $display("FAIL fill_order: got ph=%0d addr=%h data=%h required addr=%h data=%h",
                        phase, mem_addr, mem_wdata, AW'(16 + n_wr), DW'(16'hA000 + n_wr));
            else n_pass++;
            n_wr++;
         end
      end
      n_checks++;
      if (n_wr != 8 || guard >= 60)
         $display("FAIL fill_count: got %0d writes in %0d cycles required 8", n_wr, guard);
      else n_pass++;
   endtask

   task automatic test_write_read();
      int  t_issue = -1;
      bit  saw_wr  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i == 0)      drive(1'b0, 1'b1, 1'b1, 13'h0040, 16'h1234, 13'h0123, 1'b0);
         else if (i == 1) drive(1'b0, 1'b1, 1'b0, 13'h0040, 16'h0000, 13'h0123, 1'b0);
         else             drive(1'b0, 1'b0, 1'b0, '0, '0, 13'h0123, 1'b0);
         if (mem_we && mem_addr === 13'h0040 && mem_wdata === 16'h1234) saw_wr = 1'b1;
         if (!mem_we && mem_addr === 13'h0040 && t_issue < 0) t_issue = i;
         n_checks++;
         if (t_issue >= 0 && i == t_issue + 2) begin
            if (host_rvalid !== 1'b1 || host_rdata !== 16'h1234)
               $display("FAIL rw_response: got v=%b d=%h required 1/1234", host_rvalid, host_rdata);
            else n_pass++;
         end else begin
            if (host_rvalid !== 1'b0)
               $display("FAIL rw_no_pulse: got %b required 0 at cycle %0d", host_rvalid, i);
            else n_pass++;
         end
      end
      n_checks++;
      if (!saw_wr || t_issue < 0)
         $display("FAIL rw_issue: got write_seen=%b read_cycle=%0d required both", saw_wr, t_issue);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      while (m_phase != 1) drive(1'b0, 1'b0, 1'b0, '0, '0, 13'h0123, 1'b0);
      for (int i = 0; i < 3; i++)
         drive(1'b0, 1'b1, 1'b0, AW'(13'h0040 + i), '0, 13'h0123, 1'b0);
      drive(1'b1, 1'b0, 1'b0, '0, '0, 13'h0123, 1'b0);
      n_checks++;
      if (phase !== 2'd0 || host_ready !== 1'b0 || mem_we !== 1'b0 || host_rvalid !== 1'b0)
         $display("FAIL midrst_state: got ph=%0d rdy=%b we=%b hv=%b required 0/0/0/0",
                  phase, host_ready, mem_we, host_rvalid);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 1'b0, '0, '0, 13'h0123, 1'b0);
         if (i == 0) begin
            n_checks++;
            if (phase !== 2'd0 || host_ready !== 1'b1)
               $display("FAIL midrst_release: got ph=%0d rdy=%b required 0/1", phase, host_ready);
            else n_pass++;
         end
         n_checks++;
         if (host_rvalid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 13'h0123)
            $display("FAIL midrst_squash: got hv=%b we=%b addr=%h required 0/0/0123",
                     host_rvalid, mem_we, mem_addr);
         else n_pass++;
      end
   endtask

   task automatic test_vblank();
      int n_wr = 0, prev = -1, nv = 0;
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, 13'h0123, 1'b1);
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, i < 4, 1'b1, AW'(13'h0060 + i), DW'(16'hB000 + i), 13'h0123, 1'b1);
         if (vid_valid) nv++;
         if (mem_we) begin
            n_checks++;
`ifdef VRAM_ARB_VBLANK_BOOST_EN
            if (prev >= 0 && i != prev + 1)
               $display("FAIL vblank_consecutive: got issue at cycle %0d after %0d", i, prev);
`else
            if (phase != 2'd0 && phase != 2'd3)
               $display("FAIL vblank_ignored: got write in phase %0d required 0 or 3", phase);
`endif
            else n_pass++;
            prev = i;
            n_wr++;
         end
      end
      n_checks++;
`ifdef VRAM_ARB_VBLANK_BOOST_EN
      if (n_wr != 4 || nv != 0)
         $display("FAIL vblank_totals: got writes=%0d vid_pulses=%0d required 4/0", n_wr, nv);
`else
      if (n_wr != 4 || nv != 6)
         $display("FAIL vblank_totals: got writes=%0d vid_pulses=%0d required 4/6", n_wr, nv);
`endif
      else n_pass++;
   endtask

   task automatic test_random();
      logic vb = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(15) == 0) vb = ~vb;
         drive($urandom_range(79) == 0, $urandom_range(2) != 0, 1'($urandom),
               AW'($urandom_range(31)), DW'($urandom), AW'($urandom_range(31)), vb);
         n_checks++;
         if ({phase, host_ready, mem_we, vid_valid, host_rvalid} !==
             {exp_phase, exp_ready, exp_mem_we, exp_vid_valid, exp_host_rvalid})
            $display("FAIL rand_ctrl: cycle %0d got ph/rdy/we/vv/hv=%b required %b", cyc,
                     {phase, host_ready, mem_we, vid_valid, host_rvalid},
                     {exp_phase, exp_ready, exp_mem_we, exp_vid_valid, exp_host_rvalid});
         else n_pass++;
         n_checks++;
         if (vid_rdata !== exp_vid_rdata || host_rdata !== exp_host_rdata)
            $display("FAIL rand_rdata: cycle %0d got vid=%h host=%h required vid=%h host=%h",
                     cyc, vid_rdata, host_rdata, exp_vid_rdata, exp_host_rdata);
         else n_pass++;
         if (!rst) begin
            n_checks++;
            if (mem_addr !== exp_mem_addr || (exp_mem_we && mem_wdata !== exp_mem_wdata))
               $display("FAIL rand_mem: cycle %0d got addr=%h wdata=%h required addr=%h wdata=%h",
                        cyc, mem_addr, mem_wdata, exp_mem_addr, exp_mem_wdata);
            else n_pass++;
         end
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0, 13'h0123, 1'b0);
   endtask

   initial begin
      cyc = 0; m_phase = 0; m_vid = '0; m_host = '0;
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i]   = DW'(i * 37 + 16'h1F00);
         m_mem[i] = DW'(i * 37 + 16'h1F00);
      end
      mem[13'h0123]   = 16'hF81F;
      m_mem[13'h0123] = 16'hF81F;
      test_reset();
      test_video();
      test_fifo_fill();
      test_write_read();
      test_reset_mid();
      test_vblank();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000 required earlier finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
